// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the decoder scan sequencer
package scan_pkg;

  localparam int LINES = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_next_line.sv
// rtl/scan_next_line.sv - picks the next unmasked line index, upward mod LINES
module scan_next_line
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur_i,
  input  logic [LINES-1:0] mask_i,
  input  logic             first_i,
  output logic [SEL_W-1:0] next_o,
  output logic             wrapped_o
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // First-hit search; "first" scans from index 0 inclusive, otherwise from cur+1
  always_comb begin
    next_o = cur_i;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < LINES; k++) begin
      cand = first_i ? SEL_W'(k) : cur_i + SEL_W'(k + 1);
      if (!found && !mask_i[cand]) begin
        next_o = cand;
        found  = 1'b1;
      end
    end
    wrapped_o = !first_i && (next_o <= cur_i);
  end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - sweeps select/enable of a 2-to-4 decoder with dwell and blanking
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LINES-1:0]   mask,
  output logic               sel0,
  output logic               sel1,
  output logic               enable_n,
  output logic               busy,
  output logic               wrap
);

  localparam int                 BLANK_W    = $clog2(BLANK_CYCLES + 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [LINES-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               enable_n_q, enable_n_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;

  logic               start_ok;
  logic               blank_done;
  logic               dwell_done;
  logic [SEL_W-1:0]   nl_next;
  logic               nl_wrapped;

  // A start with every line masked would have nothing to drive, so it is dropped
  assign start_ok   = start && !stop && (mask != '1);
  assign blank_done = (blank_cnt_q == BLANK_LAST);
  assign dwell_done = (dwell_cnt_q == dwell_q);

  // From IDLE the search uses the live mask, since it is being latched on that edge
  scan_next_line u_next_line (
    .cur_i     (sel_q),
    .mask_i    ((state_q == IDLE) ? mask : mask_q),
    .first_i   (state_q == IDLE),
    .next_o    (nl_next),
    .wrapped_o (nl_wrapped)
  );

  // State and output registers; reset returns everything to the parked idle values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dwell_cnt_q <= '0;
      blank_cnt_q <= '0;
      dwell_q     <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      enable_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_q     <= dwell_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      enable_n_q  <= enable_n_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  // Next-state: stop aborts BLANK immediately but lets a DRIVE dwell finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = BLANK;
      BLANK:   if (stop) state_d = IDLE;
               else if (blank_done) state_d = DRIVE;
      DRIVE:   if (dwell_done) state_d = stop ? IDLE : BLANK;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; sel only moves when entering BLANK so enable_n is high
  always_comb begin
    dwell_q_hold: begin
      dwell_d = dwell_q;
      mask_d  = mask_q;
    end
    sel_d       = sel_q;
    wrap_d      = 1'b0;
    enable_n_d  = (state_d != DRIVE);
    busy_d      = (state_d != IDLE);
    blank_cnt_d = (state_q == BLANK && state_d == BLANK) ? blank_cnt_q + 1'b1 : '0;
    dwell_cnt_d = (state_q == DRIVE && state_d == DRIVE) ? dwell_cnt_q + 1'b1 : '0;
    if (state_q == IDLE && state_d == BLANK) begin
      sel_d   = nl_next;
      mask_d  = mask;
      dwell_d = dwell;
    end else if (state_q == DRIVE && state_d == BLANK) begin
      sel_d  = nl_next;
      wrap_d = nl_wrapped;
    end
  end

  assign sel0     = sel_q[0];
  assign sel1     = sel_q[1];
  assign enable_n = enable_n_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Sequential driver that feeds the 2-to-4 line decoder. It generates the 2-bit line select and the active-low decoder enable so the four decoded lines are activated one at a time in a repeating sweep. Each line is held for a programmable dwell time, and a blanking gap separates consecutive lines. Typical uses are display digit multiplexing and keypad/row scanning; outputs connect directly to the decoder's select and enable inputs.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell count input.
- BLANK_CYCLES, 2, enable-high gap between lines; legal range ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin sweeping; sampled only in IDLE.
- stop  in  1  end sweeping; a level, sampled every cycle.
- dwell  in  DWELL_W  line hold time minus one; latched at start.
- mask  in  4  bit i=1 skips line i; latched at start.
- sel0  out  1  select LSB; drives decoder input reg1.
- sel1  out  1  select MSB; drives decoder input reg2.
- enable_n  out  1  active-low decoder enable; drives decoder input enablereg.
- busy  out  1  high whenever not IDLE.
- wrap  out  1  1-cycle pulse when the select wraps to a line index ≤ the previous one.

## Operation
- All outputs are registered.
- Reset values: sel=00, enable_n=1, busy=0, wrap=0, state IDLE, counters 0.
- States and transitions:
  - IDLE: enable_n=1, sel holds its last value. start=1, stop=0 and mask≠4'hF → latch dwell/mask, set sel to the lowest unmasked index, go to BLANK.
  - BLANK: enable_n=1 for exactly BLANK_CYCLES cycles, then go to DRIVE. If stop=1 in any BLANK cycle → IDLE.
  - DRIVE: enable_n=0 for exactly dwell+1 cycles (dwell=0 gives 1 cycle). On the last cycle:
    - stop=1 → IDLE.
    - stop=0 → load sel with the next unmasked index, searching upward mod 4 from the current index+1, and go to BLANK.
- sel changes only on entry to BLANK or on leaving IDLE, and therefore only while enable_n=1. This makes the sweep glitch-free at the decoder.
- wrap: asserted in the cycle sel takes a new value during a sweep that is ≤ its previous value. The initial load from IDLE does not assert wrap. With a single unmasked line, every advance asserts wrap.
- start while busy: ignored. start with mask=4'hF: ignored. start and stop together in IDLE: stop wins, stay IDLE.
- Changes on dwell/mask while busy have no effect until the next start.
- reset mid-operation: at the next edge all outputs return to their reset values, regardless of state.

## Timing
- start sampled at edge 0 → edge 1: busy=1, sel=first line, enable_n=1.
- enable_n falls at edge 1+BLANK_CYCLES and stays low dwell+1 cycles.
- Per-line period: BLANK_CYCLES+dwell+1 cycles. Full sweep: period × (number of unmasked lines).
- stop during DRIVE: the current dwell completes; enable_n=1 and busy=0 on the same edge that ends DRIVE.
- stop during BLANK: busy=0 one edge after stop is sampled; enable_n stays 1 throughout.
- Dwell counter: DWELL_W bits, counts 0..dwell with no overflow. Blank counter: $clog2(BLANK_CYCLES+1) bits.

## Structure
- Package scan_pkg:
  - state enum {IDLE, BLANK, DRIVE}.
  - constants LINES=4 and SEL_W=2.
- Sub-module scan_next_line (combinational):
  - Inputs: current index, mask, and a "first" flag; "first" means search from index 0 inclusive.
  - Outputs: next index and a wrapped flag.
  - Instantiated once in scan_sequencer.
- Top level holds the FSM, dwell counter, blank counter, latched mask/dwell, and output registers.

## Test plan
- Reset, BLANK_CYCLES=2, mask=0000, dwell=3, pulse start → sel sequence 0,1,2,3,0; enable_n low 4 cycles and high 2 cycles per line; wrap pulses once as sel returns to 0; busy=1 throughout.
- mask=1010, dwell=1 → sel visits only lines 0 and 2; wrap pulses on every 2→0 transition; period 4 cycles.
- mask=1110, dwell=0 → sel stays 0; enable_n alternates 2 high / 1 low; wrap pulses on every advance.
- dwell=5, stop raised in the 2nd DRIVE cycle of line 2 → enable_n stays low the full 6 cycles, then enable_n=1 and busy=0 on the same edge; sel holds 2 in IDLE.
- mask=1111 with start → stays IDLE (busy=0). start and stop together in IDLE → stays IDLE. start while busy → sweep timing unchanged.
- reset asserted mid-DRIVE → next edge: sel=00, enable_n=1, busy=0, wrap=0; a subsequent start restarts cleanly from the lowest unmasked line.
